adder_stream_rx: RTL and testbench
==================================

Name: adder_stream_rx

Overview:
- Receiving end of the bit-serial full-adder result stream.
- The upstream sequencer drives S/COUT in a repeating three-phase frame after a start pulse:
  - P1: sum only, COUT=0.
  - P2: carry only, S=0.
  - P3: sum and carry.
- This block re-aligns to that frame, checks phase legality, and deserialises sum and carry bits into parallel words.
- Each completed word pair is presented through a valid/ready output buffer for downstream logic.

Parameters:
- WIDTH, 8: word width of sum_word and carry_word. Must be even and ≥2.
- START_LAT, 2: cycles between start being sampled and the first P1 sample. Covers upstream state-to-output delay. Range 0..15.

Ports:
- CLK  in  1  clock; all sampling on posedge.
- RST  in  1  asynchronous, active-high reset.
- start  in  1  frame start; sampled only in IDLE.
- abort  in  1  synchronous abort; discards the partial word.
- S_IN  in  1  serial sum bit from the sequencer.
- COUT_IN  in  1  serial carry bit from the sequencer.
- out_ready  in  1  downstream accepts the holding register.
- out_valid  out  1  holding register full.
- sum_word  out  WIDTH  assembled sum bits.
- carry_word  out  WIDTH  assembled carry bits.
- busy  out  1  state is not IDLE.
- ovf  out  1  sticky; a completed word was dropped.
- err  out  1  sticky; phase-protocol violation.

Behaviour:
- Reset (RST=1, async): state=IDLE, align counter=0, pair index=0, shift regs=0, out_valid=0, sum_word=0, carry_word=0, busy=0, ovf=0, err=0.
- States: IDLE, ALIGN, P1, P2, P3.
  - IDLE: start=1 → ALIGN, or → P1 directly if START_LAT=0. ovf and err are cleared on this edge.
  - ALIGN: counts START_LAT edges, then → P1. First P1 sample lands at edge t+START_LAT+1, where t is the edge that sampled start.
  - Phase rotation: P1 → P2 → P3 → P1. No idle gap between frames; start is ignored outside IDLE.
- Bit placement, for pair index k = 0..WIDTH/2-1:
  - P1: S_IN → sum_sh[2k].
  - P2: COUT_IN → carry_sh[2k].
  - P3: S_IN → sum_sh[2k+1] and COUT_IN → carry_sh[2k+1]; k increments.
- Word completion: at the P3 edge where k = WIDTH/2-1.
  - Shift regs copy into the holding register; out_valid=1 from the next cycle.
  - k wraps to 0 and shift regs clear.
  - Reception continues at P1 on the next edge.
- Handshake:
  - Transfer occurs on an edge with out_valid=1 and out_ready=1; out_valid drops next cycle unless reloaded.
  - sum_word/carry_word hold stable while out_valid=1 and not accepted.
- Boundary cases:
  - Completion while holding is full and out_ready=1 on the same edge: old word consumed, new word loaded, out_valid stays 1, no ovf.
  - Completion while holding is full and out_ready=0: new word dropped, holding unchanged, ovf=1 (sticky).
- abort: highest priority below RST.
  - In ALIGN/P1/P2/P3: → IDLE next edge; shift regs and k cleared.
  - Holding register, out_valid, ovf and err are unaffected.
  - No effect in IDLE. abort and start high in the same IDLE cycle: start wins.
- err (when the optional feature below is compiled in):
  - Set when COUT_IN=1 at a P1 sample or S_IN=1 at a P2 sample.
  - Offending bits are still stored as sampled; reception continues.
- busy = (state != IDLE).

Optional Feature:
- Macro: ADDER_RX_PHASE_CHK_EN.
- Defined: err checking as specified above.
- Undefined: err tied to 0, check logic absent; all other behaviour identical.

Test Plan:
- WIDTH=8, START_LAT=2. Pulse start, feed 12 phase samples encoding sum=8'hA5, carry=8'h3C (P2 COUT and P3 COUT carry bits 0,2,4,6 and 1,3,5,7), legal zeros elsewhere → out_valid=1 one cycle after 12th sample, sum_word=8'hA5, carry_word=8'h3C, err=0.
- Continuous 2-word stream with out_ready=1 throughout, second word 8'h0F/8'hF0 → two single-cycle out_valid pulses 12 cycles apart, no gap, ovf=0.
- out_ready=0, stream 2 words → first word held, second dropped, ovf=1, sum_word still first value. Then out_ready=1 → out_valid falls, ovf stays 1 until next start.
- abort asserted at pair k=2, P2 → busy=0 next cycle. Restart with a full word 8'h55/8'hAA → output exactly 8'h55/8'hAA, no partial bits leak.
- START_LAT=0: start at edge t, first P1 sample at t+1 → LSB correctly captured.
- Macro defined: COUT_IN=1 during P1 → err=1 sticky, word still delivered. Macro undefined: same stimulus → err=0.

Source files
------------

// File: rtl/adder_stream_rx.sv
// Bit-serial full-adder stream receiver: frame alignment, P1/P2/P3 deserialisation, valid/ready holding buffer.
// Optional phase-legality checking on err is compiled in with `define ADDER_RX_PHASE_CHK_EN.
module adder_stream_rx #(
   parameter int WIDTH     = 8,
   parameter int START_LAT = 2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   input  logic             abort,
   input  logic             S_IN,
   input  logic             COUT_IN,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] sum_word,
   output logic [WIDTH-1:0] carry_word,
   output logic             busy,
   output logic             ovf,
   output logic             err
);

   localparam int NPAIR = WIDTH / 2;
   localparam int KW    = (NPAIR > 1) ? $clog2(NPAIR) : 1;
   localparam logic [KW-1:0] K_LAST     = KW'(NPAIR - 1);
   localparam logic [3:0]    ALIGN_LAST = (START_LAT == 0) ? 4'd0 : 4'(START_LAT - 1);

   typedef enum logic [2:0] {IDLE, ALIGN, P1, P2, P3} state_t;

   state_t            state, state_nxt;
   logic [3:0]        align_cnt, align_nxt;
   logic [KW-1:0]     k, k_nxt;
   logic [WIDTH-1:0]  sum_sh, carry_sh;
   logic [WIDTH-1:0]  sum_asm, carry_asm;
   logic              complete, kill, clr_flags;
   logic              load, drop;

   always_comb begin
      state_nxt = state;
      align_nxt = align_cnt;
      k_nxt     = k;
      sum_asm   = sum_sh;
      carry_asm = carry_sh;
      complete  = 1'b0;
      kill      = 1'b0;
      clr_flags = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               clr_flags = 1'b1;
               align_nxt = 4'd0;
               state_nxt = (START_LAT == 0) ? P1 : ALIGN;
            end
         end
         ALIGN: begin
            if (align_cnt == ALIGN_LAST) begin
               align_nxt = 4'd0;
               state_nxt = P1;
            end else begin
               align_nxt = align_cnt + 4'd1;
            end
         end
         P1: begin
            sum_asm[{k, 1'b0}] = S_IN;
            state_nxt = P2;
         end
         P2: begin
            carry_asm[{k, 1'b0}] = COUT_IN;
            state_nxt = P3;
         end
         P3: begin
            sum_asm[{k, 1'b1}]   = S_IN;
            carry_asm[{k, 1'b1}] = COUT_IN;
            state_nxt = P1;
            if (k == K_LAST) begin
               complete = 1'b1;
               k_nxt    = '0;
            end else begin
               k_nxt = k + KW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
      // abort outranks everything except reset, including a completing P3 edge
      if (abort && state != IDLE) begin
         state_nxt = IDLE;
         align_nxt = 4'd0;
         k_nxt     = '0;
         complete  = 1'b0;
         kill      = 1'b1;
      end
   end

   assign load = complete && (!out_valid || out_ready);
   assign drop = complete && out_valid && !out_ready;
   assign busy = (state != IDLE);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         align_cnt <= 4'd0;
         k         <= '0;
         sum_sh    <= '0;
         carry_sh  <= '0;
      end else begin
         state     <= state_nxt;
         align_cnt <= align_nxt;
         k         <= k_nxt;
         sum_sh    <= (complete || kill) ? '0 : sum_asm;
         carry_sh  <= (complete || kill) ? '0 : carry_asm;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         out_valid  <= 1'b0;
         sum_word   <= '0;
         carry_word <= '0;
         ovf        <= 1'b0;
      end else begin
         if (load) begin
            out_valid  <= 1'b1;
            sum_word   <= sum_asm;
            carry_word <= carry_asm;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (clr_flags)
            ovf <= 1'b0;
         else if (drop)
            ovf <= 1'b1;
      end
   end

`ifdef ADDER_RX_PHASE_CHK_EN
   logic phase_bad;
   assign phase_bad = !abort && ((state == P1 && COUT_IN) || (state == P2 && S_IN));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         err <= 1'b0;
      else if (clr_flags)
         err <= 1'b0;
      else if (phase_bad)
         err <= 1'b1;
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_adder_stream_rx.sv
// Randomised + directed bench for adder_stream_rx: two instances (START_LAT=2 and 0) against a sample-count model.
module tb_adder_stream_rx;

`ifdef ADDER_RX_PHASE_CHK_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [1:0] start = 2'b00;
   logic       abort = 1'b0;
   logic       S_IN = 1'b0;
   logic       COUT_IN = 1'b0;
   logic       out_ready = 1'b0;
   logic       out_valid [2];
   logic [7:0] sum_word [2];
   logic [7:0] carry_word [2];
   logic       busy [2];
   logic       ovf [2];
   logic       err [2];

   int n_chk = 0;
   int n_pass = 0;

   always #5 CLK = ~CLK;

   adder_stream_rx #(.WIDTH(8), .START_LAT(2)) u_lat2 (
      .CLK(CLK), .RST(RST), .start(start[0]), .abort(abort), .S_IN(S_IN), .COUT_IN(COUT_IN),
      .out_ready(out_ready), .out_valid(out_valid[0]), .sum_word(sum_word[0]),
      .carry_word(carry_word[0]), .busy(busy[0]), .ovf(ovf[0]), .err(err[0]));

   adder_stream_rx #(.WIDTH(8), .START_LAT(0)) u_lat0 (
      .CLK(CLK), .RST(RST), .start(start[1]), .abort(abort), .S_IN(S_IN), .COUT_IN(COUT_IN),
      .out_ready(out_ready), .out_valid(out_valid[1]), .sum_word(sum_word[1]),
      .carry_word(carry_word[1]), .busy(busy[1]), .ovf(ovf[1]), .err(err[1]));

   // Model: a receiver is either idle or counting down the start latency, then
   // consumes samples numbered 0..11; sample n is phase n%3 of pair n/3.
   bit       m_act [2];
   int       m_wait [2];
   int       m_pos [2];
   bit [7:0] m_as [2], m_ac [2];
   bit       m_v [2];
   bit [7:0] m_hs [2], m_hc [2];
   bit       m_ovf [2], m_err [2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic m_reset();
      for (int d = 0; d < 2; d++) begin
         m_act[d] = 0; m_wait[d] = 0; m_pos[d] = 0; m_as[d] = 0; m_ac[d] = 0;
         m_v[d] = 0; m_hs[d] = 0; m_hc[d] = 0; m_ovf[d] = 0; m_err[d] = 0;
      end
   endtask

   task automatic m_step(input int d);
      bit done, taken;
      int k;
      done  = 0;
      taken = m_v[d] && out_ready;
      if (!m_act[d]) begin
         if (start[d]) begin
            m_act[d] = 1; m_wait[d] = (d == 0) ? 2 : 0; m_pos[d] = 0;
            m_as[d] = 0; m_ac[d] = 0; m_ovf[d] = 0; m_err[d] = 0;
         end
      end else if (abort) begin
         m_act[d] = 0; m_pos[d] = 0; m_as[d] = 0; m_ac[d] = 0;
      end else if (m_wait[d] > 0) begin
         m_wait[d]--;
      end else begin
         k = m_pos[d] / 3;
         case (m_pos[d] % 3)
            0: begin m_as[d][2*k] = S_IN; if (COUT_IN) m_err[d] = 1; end
            1: begin m_ac[d][2*k] = COUT_IN; if (S_IN) m_err[d] = 1; end
            default: begin m_as[d][2*k+1] = S_IN; m_ac[d][2*k+1] = COUT_IN; end
         endcase
         m_pos[d]++;
         if (m_pos[d] == 12) begin done = 1; m_pos[d] = 0; end
      end
      if (done) begin
         if (!m_v[d] || out_ready) begin
            m_v[d] = 1; m_hs[d] = m_as[d]; m_hc[d] = m_ac[d];
         end else begin
            m_ovf[d] = 1;
         end
         m_as[d] = 0; m_ac[d] = 0;
      end else if (taken) begin
         m_v[d] = 0;
      end
   endtask

   task automatic cmp_all();
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("vld%0d", d),  32'(out_valid[d]),  32'(m_v[d]));
         chk($sformatf("sum%0d", d),  32'(sum_word[d]),   32'(m_hs[d]));
         chk($sformatf("cry%0d", d),  32'(carry_word[d]), 32'(m_hc[d]));
         chk($sformatf("busy%0d", d), 32'(busy[d]),       32'(m_act[d]));
         chk($sformatf("ovf%0d", d),  32'(ovf[d]),        32'(m_ovf[d]));
         chk($sformatf("err%0d", d),  32'(err[d]),        32'(ERR_EN & m_err[d]));
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      m_step(0);
      m_step(1);
      #1 cmp_all();
   endtask

   // Staggered starts so both instances take their first P1 sample on the same edge.
   task automatic begin_frame();
      start = 2'b01; cyc();
      start = 2'b00; cyc();
      start = 2'b10; cyc();
      start = 2'b00;
   endtask

   task automatic send_word(input logic [7:0] s, input logic [7:0] c, input bit bad);
      for (int k = 0; k < 4; k++) begin
         S_IN = s[2*k];   COUT_IN = bad && (k == 0); cyc();
         S_IN = 1'b0;     COUT_IN = c[2*k];          cyc();
         S_IN = s[2*k+1]; COUT_IN = c[2*k+1];        cyc();
      end
      S_IN = 1'b0; COUT_IN = 1'b0;
   endtask

   task automatic stop_rx();
      abort = 1'b1; cyc();
      abort = 1'b0;
   endtask

   initial begin
      m_reset();
      #12;
      cmp_all();
      @(negedge CLK) RST = 1'b0;

      // single word held with out_ready low
      begin_frame();
      send_word(8'hA5, 8'h3C, 0);
      chk("t1_vld", 32'(out_valid[0]), 32'd1);
      chk("t1_sum", 32'(sum_word[0]), 32'hA5);
      chk("t1_cry", 32'(carry_word[1]), 32'h3C);
      out_ready = 1'b1; cyc();
      chk("t1_drain", 32'(out_valid[0]), 32'd0);
      stop_rx();

      // back-to-back words, always ready
      begin_frame();
      send_word(8'h96, 8'h69, 0);
      send_word(8'h0F, 8'hF0, 0);
      chk("t2_sum", 32'(sum_word[1]), 32'h0F);
      chk("t2_ovf", 32'(ovf[0]), 32'd0);
      stop_rx();

      // overflow: second word dropped while first still held
      out_ready = 1'b0;
      begin_frame();
      send_word(8'h11, 8'h22, 0);
      send_word(8'h33, 8'h44, 0);
      chk("t3_ovf", 32'(ovf[0]), 32'd1);
      chk("t3_hold", 32'(sum_word[0]), 32'h11);
      stop_rx();
      out_ready = 1'b1; cyc(); cyc();
      chk("t3_sticky", 32'(ovf[1]), 32'd1);

      // abort at pair 2 during P2, then a clean word
      begin_frame();
      for (int i = 0; i < 7; i++) begin S_IN = 1'b1; COUT_IN = 1'b1; cyc(); end
      S_IN = 1'b0; COUT_IN = 1'b0;
      abort = 1'b1; cyc(); abort = 1'b0;
      chk("t4_idle", 32'(busy[0]), 32'd0);
      out_ready = 1'b0;
      begin_frame();
      send_word(8'h55, 8'hAA, 0);
      chk("t4_sum", 32'(sum_word[0]), 32'h55);
      chk("t4_cry", 32'(carry_word[1]), 32'hAA);
      out_ready = 1'b1;
      stop_rx();

      // P1 carry violation
      begin_frame();
      send_word(8'hC3, 8'h5A, 1);
      chk("t5_err", 32'(err[0]), 32'(ERR_EN));
      chk("t5_sum", 32'(sum_word[1]), 32'hC3);
      stop_rx();

      // random traffic
      for (int i = 0; i < 800; i++) begin
         S_IN      = 1'($urandom);
         COUT_IN   = ($urandom_range(0, 3) == 0);
         out_ready = ($urandom_range(0, 2) != 0);
         start     = 2'($urandom_range(0, 15) == 0 ? $urandom_range(1, 3) : 0);
         abort     = ($urandom_range(0, 63) == 0);
         cyc();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
